// File: rtl/mov_avg_pkg.sv
// Shared types and width helpers for the moving-average filter.
package mov_avg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FLUSH = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_RUN   = 2'd2;

    // Running sum of N samples needs LOG2_N growth bits, so it cannot overflow.
    function automatic int sum_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

    function automatic int ptr_w(input int log2_n);
        return log2_n;
    endfunction

    // Fill count must be able to hold N itself.
    function automatic int cnt_w(input int log2_n);
        return log2_n + 1;
    endfunction

endpackage

// File: rtl/mov_avg_ring.sv
// Per-channel circular sample buffer: one write port, read of the entry about to be overwritten.
module mov_avg_ring #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [LOG2_N-1:0] wr_ptr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**LOG2_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**LOG2_N; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[wr_ptr];

endmodule

// File: rtl/moving_avg_filt_iq.sv
// Multi-channel boxcar filter with flush and primed indication.
// Define MOV_AVG_ROUND_EN for round-half-up output instead of floor.
module moving_avg_filt_iq
    import mov_avg_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 4,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     primed
);

    localparam int N  = 2**LOG2_N;
    localparam int SW = sum_w(DATA_W, LOG2_N);
    localparam int PW = ptr_w(LOG2_N);
    localparam int CW = cnt_w(LOG2_N);

    state_t                        state;
    logic [PW-1:0]                 wr_ptr;
    logic [PW-1:0]                 flush_cnt;
    logic [CW-1:0]                 count;
    logic [NUM_CH-1:0][SW-1:0]     sum_q;
    logic [NUM_CH-1:0][SW-1:0]     sum_d;
    logic [NUM_CH-1:0][DATA_W-1:0] old_d;
    logic [NUM_CH-1:0][DATA_W-1:0] avg_d;
    logic                          flushing;
    logic                          accept;

    assign flushing = (state == ST_FLUSH);
    assign in_ready = !flushing && !clear;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] x;
        assign x = in_data[k*DATA_W +: DATA_W];

        // During FLUSH the ring walks wr_ptr and zeroes every entry.
        mov_avg_ring #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_ring (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (accept || flushing),
            .wr_ptr  (wr_ptr),
            .wr_data (flushing ? {DATA_W{1'b0}} : x),
            .rd_data (old_d[k])
        );

        assign sum_d[k] = sum_q[k] + {{LOG2_N{x[DATA_W-1]}}, x}
                                   - {{LOG2_N{old_d[k][DATA_W-1]}}, old_d[k]};

`ifdef MOV_AVG_ROUND_EN
        localparam logic signed [SW:0] HALF = (SW+1)'(N/2);
        localparam logic signed [SW:0] MAXV = (SW+1)'(2**(DATA_W-1) - 1);
        logic signed [SW:0] rnd;
        logic signed [SW:0] rsh;
        assign rnd      = $signed({sum_d[k][SW-1], sum_d[k]}) + HALF;
        assign rsh      = rnd >>> LOG2_N;
        assign avg_d[k] = (rsh > MAXV) ? DATA_W'(MAXV) : DATA_W'(rsh);
`else
        assign avg_d[k] = DATA_W'($signed(sum_d[k]) >>> LOG2_N);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FILL;
            wr_ptr    <= '0;
            flush_cnt <= '0;
            count     <= '0;
            sum_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else begin
            out_valid <= accept;
            if (clear) begin
                state     <= ST_FLUSH;
                wr_ptr    <= '0;
                flush_cnt <= '0;
                count     <= '0;
                sum_q     <= '0;
                primed    <= 1'b0;
            end else if (flushing) begin
                wr_ptr    <= wr_ptr + 1'b1;
                flush_cnt <= flush_cnt + 1'b1;
                if (flush_cnt == PW'(N-1)) begin
                    state  <= ST_FILL;
                    wr_ptr <= '0;
                end
            end else if (accept) begin
                sum_q    <= sum_d;
                out_data <= avg_d;
                wr_ptr   <= wr_ptr + 1'b1;
                if (state == ST_FILL) begin
                    count <= count + 1'b1;
                    if (count == CW'(N-1)) begin
                        state  <= ST_RUN;
                        primed <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_avg_filt_iq.sv
// Randomized and directed bench for moving_avg_filt_iq against a window-sum reference model.
module tb_moving_avg_filt_iq;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int N  = 16;
    localparam int NC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [NC*DW-1:0] in_data;
    logic             out_valid;
    logic [NC*DW-1:0] out_data;
    logic             primed;

    moving_avg_filt_iq #(.DATA_W(DW), .LOG2_N(LN), .NUM_CH(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: the last N samples per channel, as the spec describes the window.
    int win [NC][N];
    int mptr, mcnt, flush_left;
    bit mprimed, exp_valid;
    int exp_out [NC];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int avg(input int s_in);
        int s, q;
        s = s_in;
`ifdef MOV_AVG_ROUND_EN
        s = s + N/2;
`endif
        q = s / N;
        if ((s % N != 0) && (s < 0)) q = q - 1;
        if (q > 32767) q = 32767;
        return q;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            for (int i = 0; i < N; i++) win[k][i] = 0;
            exp_out[k] = 0;
        end
        mptr = 0; mcnt = 0; flush_left = 0; mprimed = 0; exp_valid = 0;
    endtask

    task automatic step(input bit v, input int d0, input int d1, input bit clr);
        int d [NC];
        int s;
        d[0] = d0; d[1] = d1;
        in_valid = v;
        in_data  = {16'(d1), 16'(d0)};
        clear    = clr;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!clr && flush_left == 0)});
        if (clr) begin
            for (int k = 0; k < NC; k++)
                for (int i = 0; i < N; i++) win[k][i] = 0;
            mptr = 0; mcnt = 0; mprimed = 0; exp_valid = 0; flush_left = N;
        end else if (v && flush_left == 0) begin
            for (int k = 0; k < NC; k++) begin
                win[k][mptr] = d[k];
                s = 0;
                for (int i = 0; i < N; i++) s += win[k][i];
                exp_out[k] = avg(s);
            end
            mptr = (mptr + 1) % N;
            if (mcnt < N) mcnt++;
            if (mcnt == N) mprimed = 1;
            exp_valid = 1;
        end else begin
            exp_valid = 0;
            if (flush_left > 0) flush_left--;
        end
        @(posedge clk);
        #2;
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        check("primed", {31'd0, primed}, {31'd0, mprimed});
        for (int k = 0; k < NC; k++)
            check($sformatf("out_data[%0d]", k), $signed(out_data[k*DW +: DW]), exp_out[k]);
    endtask

    task automatic flush_idle();
        step(0, 0, 0, 1);
        for (int i = 0; i < N; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_primed", {31'd0, primed}, 0);
        check("rst_out_data", {1'b0, out_data}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);

        // Step response into a fresh window.
        for (int i = 0; i < 20; i++) step(1, 1600, -1600, 0);
        check("step_final_ch0", $signed(out_data[15:0]), 1600);

        // Clear mid-RUN while still offering samples.
        step(1, 999, 999, 1);
        for (int i = 0; i < N; i++) step(1, 777, -777, 0);
        step(1, 1600, -1600, 0);
        check("post_flush_ch0", $signed(out_data[15:0]), 100);

        // Full scale in both directions.
        flush_idle();
        for (int i = 0; i < N; i++) step(1, 32767, -32768, 0);
        for (int i = 0; i < N; i++) step(1, -32768, 32767, 0);

        // Rounding boundaries.
        flush_idle();
        step(1, -1, 1, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0);
        flush_idle();
        step(1, 8, -8, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0);

        // Sparse input: the window only advances on accepts.
        flush_idle();
        for (int i = 1; i <= 3; i++) begin
            step(1, 16*i, -16*i, 0);
            step(0, 5, 5, 0);
            step(0, 5, 5, 0);
        end

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 24) == 0);
        end

        // Asynchronous reset between edges.
        in_valid = 1'b0; clear = 1'b0;
        for (int i = 0; i < 20; i++) step(1, 3000, -3000, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_out_data", {1'b0, out_data}, 0);
        check("arst_primed", {31'd0, primed}, 0);
        check("arst_out_valid", {31'd0, out_valid}, 0);
        #1 rst = 1'b0;
        step(1, 160, -160, 0);
        check("arst_first_ch0", $signed(out_data[15:0]), 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
